// File: rtl/morse_lcd_pkg.sv
// Shared constants, state encodings and the character-code to LCD-glyph mapping
// for the Morse receiver LCD controller.
package morse_lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_ROW1     = 8'h80;

  localparam logic [4:0] CHAR_SPACE = 5'd31;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } wr_state_t;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_ADDR,
    ST_CHAR
  } ctrl_state_t;

  // Codes 26..30 have no letter assigned and show as '?'.
  function automatic logic [7:0] code_to_ascii(input logic [4:0] code);
    logic [7:0] ascii;
    if (code <= 5'd25) begin
      ascii = 8'h41 + {3'b000, code};
    end else if (code == CHAR_SPACE) begin
      ascii = 8'h20;
    end else begin
      ascii = 8'h3F;
    end
    return ascii;
  endfunction

endpackage

// File: rtl/morse_lcd_refresh_ctrl_lcd_byte_writer.sv
// Drives one byte onto the HD44780 bus: SETUP (1 cycle), PULSE (EN high), HOLD (wait).
// Handshake: start is accepted when the writer is idle or in the cycle done is high;
// done is high for exactly the last HOLD cycle, so a start there gives back-to-back bytes.
module lcd_byte_writer
  import morse_lcd_pkg::*;
#(
  parameter int EN_CYCLES  = 25,
  parameter int CMD_WAIT   = 2500,
  parameter int CLEAR_WAIT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       rs_in,
  input  logic       is_clear,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic       done,
  output wr_state_t  dbg_state
);

  localparam int CW = $clog2(EN_CYCLES + CMD_WAIT + CLEAR_WAIT + 1);

  wr_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   hold_last;
  logic [7:0]      data_q, data_d;
  logic            rs_q, rs_d;
  logic            clear_q, clear_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WR_IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      clear_q <= clear_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    rs_d      = rs_q;
    clear_d   = clear_q;
    done      = 1'b0;
    hold_last = clear_q ? CW'(CLEAR_WAIT - 1) : CW'(CMD_WAIT - 1);
    case (state_q)
      WR_IDLE: ;
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = '0;
      end
      WR_PULSE: begin
        if (cnt_q == CW'(EN_CYCLES - 1)) begin
          state_d = WR_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WR_HOLD: begin
        if (cnt_q == hold_last) begin
          done    = 1'b1;
          state_d = WR_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = WR_IDLE;
    endcase
    // Data and RS only change here, so they stay frozen across PULSE and HOLD.
    if (start && (state_q == WR_IDLE || done)) begin
      state_d = WR_SETUP;
      data_d  = byte_in;
      rs_d    = rs_in;
      clear_d = is_clear;
    end
  end

  assign lcd_data  = data_q;
  assign lcd_rs    = rs_q;
  assign lcd_en    = (state_q == WR_PULSE);
  assign dbg_state = state_q;

endmodule

// File: rtl/morse_lcd_refresh_ctrl.sv
// Owns the character LCD: power-up wait, init commands, then a full row-1 rewrite
// whenever the decoded-character buffer differs from the last one written.
module morse_lcd_refresh_ctrl
  import morse_lcd_pkg::*;
#(
  parameter int POWERUP_WAIT = 750000,
  parameter int EN_CYCLES    = 25,
  parameter int CMD_WAIT     = 2500,
  parameter int CLEAR_WAIT   = 100000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEnable,
  input  logic [39:0] iDisplayData,
  output logic [7:0]  oLCD_DATA,
  output logic        oLCD_RS,
  output logic        oLCD_RW,
  output logic        oLCD_EN,
  output logic        oBusy
);

  localparam int PW = $clog2(POWERUP_WAIT + 1);

  ctrl_state_t   state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [PW-1:0] pw_cnt_q, pw_cnt_d;
  logic [39:0]   snap_q, snap_d;
  logic          send;
  logic [7:0]    wr_byte;
  logic          wr_rs;
  logic          wr_clear;
  logic          wr_done;
  logic [5:0]    col_shift;
  logic [4:0]    col_code;
  wr_state_t     wr_state;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= ST_PWR_WAIT;
      idx_q    <= 3'd0;
      pw_cnt_q <= '0;
      snap_q   <= {40{1'b1}};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pw_cnt_q <= pw_cnt_d;
      snap_q   <= snap_d;
    end
  end

  // A new byte is launched in the same cycle the previous one reports done.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pw_cnt_d = pw_cnt_q;
    snap_d   = snap_q;
    send     = 1'b0;
    case (state_q)
      ST_PWR_WAIT: begin
        if (pw_cnt_q == PW'(POWERUP_WAIT - 1)) begin
          state_d = ST_INIT;
          idx_d   = 3'd0;
          send    = 1'b1;
        end else begin
          pw_cnt_d = pw_cnt_q + PW'(1);
        end
      end
      ST_INIT: begin
        if (wr_done) begin
          if (idx_q == 3'd3) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
            send  = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (iEnable && (iDisplayData != snap_q)) begin
          snap_d  = iDisplayData;
          state_d = ST_ADDR;
          send    = 1'b1;
        end
      end
      ST_ADDR: begin
        if (wr_done) begin
          state_d = ST_CHAR;
          idx_d   = 3'd0;
          send    = 1'b1;
        end
      end
      ST_CHAR: begin
        if (wr_done) begin
          if (idx_q == 3'd7) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
            send  = 1'b1;
          end
        end
      end
      default: state_d = ST_PWR_WAIT;
    endcase
  end

  // Byte content follows the state/index being entered; column 0 is the oldest code.
  always_comb begin
    col_shift = {3'b000, idx_d} * 6'd5;
    col_code  = 5'(snap_q >> (6'd35 - col_shift));
    wr_rs     = 1'b0;
    wr_byte   = CMD_ROW1;
    case (state_d)
      ST_INIT: begin
        case (idx_d)
          3'd0:    wr_byte = CMD_FUNC_SET;
          3'd1:    wr_byte = CMD_DISP_ON;
          3'd2:    wr_byte = CMD_CLEAR;
          default: wr_byte = CMD_ENTRY;
        endcase
      end
      ST_CHAR: begin
        wr_rs   = 1'b1;
        wr_byte = code_to_ascii(col_code);
      end
      default: ;
    endcase
    wr_clear = !wr_rs && (wr_byte == CMD_CLEAR);
  end

  lcd_byte_writer #(
    .EN_CYCLES  (EN_CYCLES),
    .CMD_WAIT   (CMD_WAIT),
    .CLEAR_WAIT (CLEAR_WAIT)
  ) u_writer (
    .clk       (iCLK),
    .rst       (iRST),
    .start     (send),
    .byte_in   (wr_byte),
    .rs_in     (wr_rs),
    .is_clear  (wr_clear),
    .lcd_data  (oLCD_DATA),
    .lcd_rs    (oLCD_RS),
    .lcd_en    (oLCD_EN),
    .done      (wr_done),
    .dbg_state (wr_state)
  );

  assign oLCD_RW = 1'b0;
  assign oBusy   = (state_q != ST_IDLE) || (wr_state != WR_IDLE);

endmodule
